dev_dumper: RTL

- Reads a contiguous RAM region byte by byte and emits it as ASCII hex text on a byte stream feeding the UART transmitter.
- Output format: two uppercase hex digits per byte, separated by space or line feed, terminated by EOT (0x04).
- Output is directly reloadable by the hex loader, which ignores non-hex characters and stops on 0x04.
- Sits beside the loader on the device side; host firmware/debug logic triggers it with start, base address and length.

---
 rtl/dev_dumper.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dev_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : dev_dumper
//  Purpose  : Streams a contiguous RAM region out as uppercase ASCII hex text
//             (space / line-feed separated, EOT terminated) for the UART.
//  Revision : 1.0  initial release
// ============================================================================
module dev_dumper #(
    parameter int ADDRW          = 16,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [ADDRW:0]   length,
    output logic             ram_rd,
    output logic [ADDRW-1:0] ram_addr,
    input  logic [7:0]       ram_rdata,
    input  logic             ram_rvalid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam int c_COLW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam logic [c_COLW-1:0] c_LAST_COL = c_COLW'(BYTES_PER_LINE - 1);
    localparam logic [c_COLW-1:0] c_COL_ONE  = 1;
    localparam logic [ADDRW:0]    c_CNT_ONE  = 1;

    localparam logic [7:0] c_CHR_SPACE = 8'h20;
    localparam logic [7:0] c_CHR_LF    = 8'h0A;
    localparam logic [7:0] c_CHR_EOT   = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HI    = 3'd3,
        S_LO    = 3'd4,
        S_SEP   = 3'd5,
        S_EOT   = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ADDRW-1:0]   r_base;
    logic [ADDRW:0]     r_len;
    logic [ADDRW:0]     r_cnt;
    logic [7:0]         r_data;
    logic [c_COLW-1:0]  r_col;
    logic               r_eol;
    logic               r_done;
    logic               w_last;

    function automatic logic [7:0] f_hex(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign w_last = (r_cnt == r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: request latch, byte counter and position within the text line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_col  <= '0;
            r_eol  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_EOT) && tx_ready;
            if ((r_state == S_IDLE) && start) begin
                r_base <= base_addr;
                r_len  <= length;
                r_cnt  <= '0;
                r_col  <= '0;
                r_eol  <= 1'b0;
            end
            if ((r_state == S_WAIT) && ram_rvalid) begin
                r_data <= ram_rdata;
                r_cnt  <= r_cnt + c_CNT_ONE;
                // r_eol tracks "counter mod BYTES_PER_LINE == 0" without a divider
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                    r_eol <= 1'b1;
                end else begin
                    r_col <= r_col + c_COL_ONE;
                    r_eol <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        ram_rd       = 1'b0;
        ram_addr     = '0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        busy         = (r_state != S_IDLE);
        done         = r_done;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (length != '0) ? S_FETCH : S_EOT;
                end
            end
            S_FETCH: begin
                ram_rd       = 1'b1;
                ram_addr     = r_base + r_cnt[ADDRW-1:0];
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (ram_rvalid) begin
                    w_state_next = S_HI;
                end
            end
            S_HI: begin
                tx_valid = 1'b1;
                tx_data  = f_hex(r_data[7:4]);
                if (tx_ready) begin
                    w_state_next = S_LO;
                end
            end
            S_LO: begin
                tx_valid = 1'b1;
                tx_data  = f_hex(r_data[3:0]);
                if (tx_ready) begin
                    w_state_next = S_SEP;
                end
            end
            S_SEP: begin
                tx_valid = 1'b1;
                tx_data  = (w_last || r_eol) ? c_CHR_LF : c_CHR_SPACE;
                if (tx_ready) begin
                    w_state_next = w_last ? S_EOT : S_FETCH;
                end
            end
            S_EOT: begin
                tx_valid = 1'b1;
                tx_data  = c_CHR_EOT;
                if (tx_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
